// File: rtl/rename_map_if.sv
// rename_map_if: bundles the rename stage's decode, freelist, dispatch and
// commit signals.
//   slave  - the rename stage view (rename_map)
//   master - the surrounding pipeline / freelist view (drives decode,
//            alloc and commit inputs, observes renamed outputs)
interface rename_map_if #(
    parameter int ARCH_SEL = 5,
    parameter int PHYS_SEL = 6
);
    // pipeline control
    logic                prmiss;
    logic                stall_DP;
    logic                stall_RN;
    // decode slots
    logic                inst_valid_1, inst_valid_2;
    logic [ARCH_SEL-1:0] rs1_1, rs2_1, rd_1;
    logic [ARCH_SEL-1:0] rs1_2, rs2_2, rd_2;
    logic                wr_1, wr_2;
    // freelist alloc side
    logic [PHYS_SEL-1:0] alloc_1, alloc_2;
    logic                alloc_valid_1, alloc_valid_2;
    logic                allocatable;
    logic                invalid_1, invalid_2;
    // dispatch side
    logic                out_valid_1, out_valid_2;
    logic [PHYS_SEL-1:0] prs1_1, prs2_1, prd_1, pold_1;
    logic [PHYS_SEL-1:0] prs1_2, prs2_2, prd_2, pold_2;
    // commit and freelist release side
    logic                com_valid_1, com_valid_2;
    logic [ARCH_SEL-1:0] com_rd_1, com_rd_2;
    logic [PHYS_SEL-1:0] com_prd_1, com_prd_2;
    logic [PHYS_SEL-1:0] released_1, released_2;
    logic                released_valid_1, released_valid_2;

    modport slave (
        input  prmiss, stall_DP,
        input  inst_valid_1, inst_valid_2,
        input  rs1_1, rs2_1, rd_1, rs1_2, rs2_2, rd_2, wr_1, wr_2,
        input  alloc_1, alloc_2, alloc_valid_1, alloc_valid_2, allocatable,
        input  com_valid_1, com_valid_2, com_rd_1, com_rd_2, com_prd_1, com_prd_2,
        output stall_RN, invalid_1, invalid_2,
        output out_valid_1, out_valid_2,
        output prs1_1, prs2_1, prd_1, pold_1, prs1_2, prs2_2, prd_2, pold_2,
        output released_1, released_2, released_valid_1, released_valid_2
    );

    modport master (
        output prmiss, stall_DP,
        output inst_valid_1, inst_valid_2,
        output rs1_1, rs2_1, rd_1, rs1_2, rs2_2, rd_2, wr_1, wr_2,
        output alloc_1, alloc_2, alloc_valid_1, alloc_valid_2, allocatable,
        output com_valid_1, com_valid_2, com_rd_1, com_rd_2, com_prd_1, com_prd_2,
        input  stall_RN, invalid_1, invalid_2,
        input  out_valid_1, out_valid_2,
        input  prs1_1, prs2_1, prd_1, pold_1, prs1_2, prs2_2, prd_2, pold_2,
        input  released_1, released_2, released_valid_1, released_valid_2
    );
endinterface

// File: rtl/rename_map.sv
// rename_map: two-wide register rename stage.
//   clk, reset - clock and synchronous active-high reset
//   rn         - rename_map_if.slave: decode slots in, freelist alloc tags in /
//                invalid lines out, renamed slots out to dispatch (registered),
//                commit ports in, superseded tags out to freelist (registered)
// Keeps a speculative map (read by rename, written on fire) and a committed
// map (written by commit). A mispredict copies the committed map, including
// the same-cycle commit writes, over the speculative map.
module rename_map #(
    parameter int ARCH_NUM = 32,
    parameter int ARCH_SEL = 5,
    parameter int PHYS_SEL = 6
) (
    input logic         clk,
    input logic         reset,
    rename_map_if.slave rn
);
    logic [PHYS_SEL-1:0] spec_map    [ARCH_NUM];
    logic [PHYS_SEL-1:0] commit_map  [ARCH_NUM];
    logic [PHYS_SEL-1:0] commit_next [ARCH_NUM];

    logic need_1, need_2, fire;
    logic [PHYS_SEL-1:0] prs1_1_c, prs2_1_c, pold_1_c, prd_1_c;
    logic [PHYS_SEL-1:0] prs1_2_c, prs2_2_c, pold_2_c, prd_2_c;
    logic [PHYS_SEL-1:0] rel_1_c, rel_2_c;
    logic                relv_1_c, relv_2_c;

    // The freelist guarantees the tags through allocatable; the per-slot
    // valid lines carry no extra information here.
    logic unused_alloc_valid;
    assign unused_alloc_valid = rn.alloc_valid_1 ^ rn.alloc_valid_2;

    assign need_1 = rn.inst_valid_1 & rn.wr_1 & (rn.rd_1 != '0);
    assign need_2 = rn.inst_valid_2 & rn.wr_2 & (rn.rd_2 != '0);

    assign rn.invalid_1 = ~need_1;
    assign rn.invalid_2 = ~need_2;
    assign rn.stall_RN  = rn.stall_DP | ((need_1 | need_2) & ~rn.allocatable);
    assign fire = (rn.inst_valid_1 | rn.inst_valid_2) & ~rn.stall_RN & ~rn.prmiss;

    // Source/old-dest lookup. x0 is forced to tag 0; slot 2 bypasses the
    // tag slot 1 is allocating in this same group.
    always_comb begin
        prs1_1_c = (rn.rs1_1 == '0) ? '0 : spec_map[rn.rs1_1];
        prs2_1_c = (rn.rs2_1 == '0) ? '0 : spec_map[rn.rs2_1];
        pold_1_c = spec_map[rn.rd_1];
        prd_1_c  = need_1 ? rn.alloc_1 : '0;

        prs1_2_c = (rn.rs1_2 == '0) ? '0 : spec_map[rn.rs1_2];
        if (need_1 && rn.rs1_2 == rn.rd_1) prs1_2_c = rn.alloc_1;
        prs2_2_c = (rn.rs2_2 == '0) ? '0 : spec_map[rn.rs2_2];
        if (need_1 && rn.rs2_2 == rn.rd_1) prs2_2_c = rn.alloc_1;
        pold_2_c = (need_1 && rn.rd_2 == rn.rd_1) ? rn.alloc_1 : spec_map[rn.rd_2];
        prd_2_c  = need_2 ? rn.alloc_2 : '0;
    end

    // Commit update, slot 1 applied first so a same-rd slot 2 releases
    // slot 1's tag and leaves its own tag in the map.
    always_comb begin
        commit_next = commit_map;
        rel_1_c  = '0;
        rel_2_c  = '0;
        relv_1_c = 1'b0;
        relv_2_c = 1'b0;
        if (rn.com_valid_1 && rn.com_rd_1 != '0) begin
            rel_1_c  = commit_next[rn.com_rd_1];
            relv_1_c = 1'b1;
            commit_next[rn.com_rd_1] = rn.com_prd_1;
        end
        if (rn.com_valid_2 && rn.com_rd_2 != '0) begin
            rel_2_c  = commit_next[rn.com_rd_2];
            relv_2_c = 1'b1;
            commit_next[rn.com_rd_2] = rn.com_prd_2;
        end
    end

    // Speculative map: reset > mispredict restore > rename write.
    // Slot 2's write is issued last so it wins on a shared rd.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARCH_NUM; i++) spec_map[i] <= PHYS_SEL'(i);
        end else if (rn.prmiss) begin
            spec_map <= commit_next;
        end else if (fire) begin
            if (need_1) spec_map[rn.rd_1] <= rn.alloc_1;
            if (need_2) spec_map[rn.rd_2] <= rn.alloc_2;
        end
    end

    // Committed map and release ports run every cycle, independent of
    // fire and prmiss.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARCH_NUM; i++) commit_map[i] <= PHYS_SEL'(i);
            rn.released_1       <= '0;
            rn.released_2       <= '0;
            rn.released_valid_1 <= 1'b0;
            rn.released_valid_2 <= 1'b0;
        end else begin
            commit_map          <= commit_next;
            rn.released_1       <= rel_1_c;
            rn.released_2       <= rel_2_c;
            rn.released_valid_1 <= relv_1_c;
            rn.released_valid_2 <= relv_2_c;
        end
    end

    // Output register to dispatch. Held under stall_DP, except that a
    // mispredict always kills the valids.
    always_ff @(posedge clk) begin
        if (reset) begin
            rn.out_valid_1 <= 1'b0;
            rn.out_valid_2 <= 1'b0;
            rn.prs1_1 <= '0; rn.prs2_1 <= '0; rn.prd_1 <= '0; rn.pold_1 <= '0;
            rn.prs1_2 <= '0; rn.prs2_2 <= '0; rn.prd_2 <= '0; rn.pold_2 <= '0;
        end else begin
            if (!rn.stall_DP) begin
                rn.out_valid_1 <= fire & rn.inst_valid_1;
                rn.out_valid_2 <= fire & rn.inst_valid_2;
                rn.prs1_1 <= prs1_1_c; rn.prs2_1 <= prs2_1_c;
                rn.prd_1  <= prd_1_c;  rn.pold_1 <= pold_1_c;
                rn.prs1_2 <= prs1_2_c; rn.prs2_2 <= prs2_2_c;
                rn.prd_2  <= prd_2_c;  rn.pold_2 <= pold_2_c;
            end
            if (rn.prmiss) begin
                rn.out_valid_1 <= 1'b0;
                rn.out_valid_2 <= 1'b0;
            end
        end
    end
endmodule
